// File: rtl/lh_pkg.sv
// Shared constants, state encoding and character legality for the light-hash framer.
// Optional build macro: LH_FRAMER_ALNUM_ONLY_EN restricts legal characters to 0-9, A-Z, a-z.
package lh_pkg;

  localparam logic [7:0] HEAD_BYTE = 8'hFF;
  localparam logic [7:0] TAIL_BYTE = 8'h00;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;
  localparam logic [7:0] DIGIT_LO  = 8'h30;
  localparam logic [7:0] DIGIT_HI  = 8'h39;
  localparam logic [7:0] UPPER_LO  = 8'h41;
  localparam logic [7:0] UPPER_HI  = 8'h5A;
  localparam logic [7:0] LOWER_LO  = 8'h61;
  localparam logic [7:0] LOWER_HI  = 8'h7A;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    ERR     = 3'd1,
    HEAD    = 3'd2,
    BODY    = 3'd3,
    TAIL    = 3'd4
  } framer_state_t;

  // HEAD_BYTE and TAIL_BYTE fall outside every legal range, so they can never appear in a body.
  function automatic logic is_legal_char(input logic [7:0] c);
`ifdef LH_FRAMER_ALNUM_ONLY_EN
    return ((c >= DIGIT_LO) && (c <= DIGIT_HI)) ||
           ((c >= UPPER_LO) && (c <= UPPER_HI)) ||
           ((c >= LOWER_LO) && (c <= LOWER_HI));
`else
    return (c >= PRINT_LO) && (c <= PRINT_HI);
`endif
  endfunction

endpackage

// File: rtl/lh_byte_buffer.sv
// MAX_LEN x 8 register array with write/read pointers and a clear; the framer owns the fill count.
module lh_byte_buffer #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_adv,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] rd_ptr
);

  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]       mem_reg [MAX_LEN];
  logic [AW-1:0]    wr_ptr_reg;
  logic [CNT_W-1:0] rd_ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          mem_reg[gi] <= 8'h00;
        end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Read pointer is one bit wider so the framer can compare it against the full count.
  assign rd_data = mem_reg[rd_ptr_reg[AW-1:0]];
  assign rd_ptr  = rd_ptr_reg;

endmodule

// File: rtl/lh_msg_framer.sv
// Store-and-forward framer: buffers one ASCII message, then emits FF, body, 00 to the hash core.
// Optional build macro: LH_FRAMER_ALNUM_ONLY_EN (see lh_pkg::is_legal_char).
module lh_msg_framer
  import lh_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       message_byte,
  output logic             message_valid,
  input  logic             message_ready,
  output logic [CNT_W-1:0] msg_len,
  output logic             err_invalid_char,
  output logic             err_too_long,
  output logic             busy
);

  framer_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             bad_reg, bad_next;
  logic             ovf_reg, ovf_next;
  logic             in_ready_reg, in_ready_next;
  logic             mvalid_reg, mvalid_next;
  logic [7:0]       mbyte_reg, mbyte_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic             err_inv_reg, err_inv_next;
  logic             err_long_reg, err_long_next;
  logic             busy_reg;

  logic             accept, out_xfer, at_cap, bad_now, ovf_now;
  logic             buf_wr, buf_adv, buf_clr;
  logic [7:0]       buf_rd_data;
  logic [CNT_W-1:0] buf_rd_ptr;

  assign accept   = in_valid && in_ready_reg;
  assign out_xfer = mvalid_reg && message_ready;
  assign at_cap   = (cnt_reg >= CNT_W'(MAX_LEN));
  assign bad_now  = bad_reg || !is_legal_char(in_byte);
  assign ovf_now  = ovf_reg || at_cap;

  assign buf_wr  = (state_reg == COLLECT) && accept && !at_cap;
  assign buf_adv = out_xfer && ((state_reg == HEAD) ||
                                ((state_reg == BODY) && (buf_rd_ptr != cnt_reg)));
  assign buf_clr = (state_reg == ERR) || ((state_reg == TAIL) && out_xfer);

  lh_byte_buffer #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (in_byte),
    .rd_adv  (buf_adv),
    .rd_data (buf_rd_data),
    .rd_ptr  (buf_rd_ptr)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bad_next      = bad_reg;
    ovf_next      = ovf_reg;
    in_ready_next = in_ready_reg;
    mvalid_next   = mvalid_reg;
    mbyte_next    = mbyte_reg;
    len_next      = len_reg;
    err_inv_next  = 1'b0;
    err_long_next = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (accept) begin
          bad_next = bad_now;
          ovf_next = ovf_now;
          if (cnt_reg != CNT_W'(MAX_LEN + 1)) cnt_next = cnt_reg + 1'b1;
          if (in_last) begin
            in_ready_next = 1'b0;
            // An illegal character outranks an over-length message.
            if (bad_now) begin
              state_next   = ERR;
              err_inv_next = 1'b1;
            end else if (ovf_now) begin
              state_next    = ERR;
              err_long_next = 1'b1;
            end else begin
              state_next  = HEAD;
              mvalid_next = 1'b1;
              mbyte_next  = HEAD_BYTE;
              len_next    = cnt_reg + 1'b1;
            end
          end
        end
      end
      ERR: begin
        state_next    = COLLECT;
        cnt_next      = '0;
        bad_next      = 1'b0;
        ovf_next      = 1'b0;
        in_ready_next = 1'b1;
      end
      HEAD: begin
        if (out_xfer) begin
          state_next = BODY;
          mbyte_next = buf_rd_data;
        end
      end
      BODY: begin
        // buf_rd_ptr already points past the byte being presented.
        if (out_xfer) begin
          if (buf_rd_ptr == cnt_reg) begin
            state_next = TAIL;
            mbyte_next = TAIL_BYTE;
          end else begin
            mbyte_next = buf_rd_data;
          end
        end
      end
      TAIL: begin
        if (out_xfer) begin
          state_next    = COLLECT;
          mvalid_next   = 1'b0;
          cnt_next      = '0;
          bad_next      = 1'b0;
          ovf_next      = 1'b0;
          in_ready_next = 1'b1;
        end
      end
      default: begin
        state_next    = COLLECT;
        in_ready_next = 1'b1;
        mvalid_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= COLLECT;
      cnt_reg      <= '0;
      bad_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      in_ready_reg <= 1'b1;
      mvalid_reg   <= 1'b0;
      mbyte_reg    <= 8'h00;
      len_reg      <= '0;
      err_inv_reg  <= 1'b0;
      err_long_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bad_reg      <= bad_next;
      ovf_reg      <= ovf_next;
      in_ready_reg <= in_ready_next;
      mvalid_reg   <= mvalid_next;
      mbyte_reg    <= mbyte_next;
      len_reg      <= len_next;
      err_inv_reg  <= err_inv_next;
      err_long_reg <= err_long_next;
      busy_reg     <= (state_next != COLLECT);
    end
  end

  assign in_ready         = in_ready_reg;
  assign message_valid    = mvalid_reg;
  assign message_byte     = mbyte_reg;
  assign msg_len          = len_reg;
  assign err_invalid_char = err_inv_reg;
  assign err_too_long     = err_long_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_lh_msg_framer.sv
// Directed, table-driven bench for lh_msg_framer plus hand-written stall and reset sequences.
module tb_lh_msg_framer;

  localparam int MAX_LEN = 32;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  logic             clk;
  logic             rst;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [7:0]       message_byte;
  logic             message_valid;
  logic             message_ready;
  logic [CNT_W-1:0] msg_len;
  logic             err_invalid_char;
  logic             err_too_long;
  logic             busy;

  lh_msg_framer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_byte          (in_byte),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .message_byte     (message_byte),
    .message_valid    (message_valid),
    .message_ready    (message_ready),
    .msg_len          (msg_len),
    .err_invalid_char (err_invalid_char),
    .err_too_long     (err_too_long),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // exp: 0 = frame, 1 = dropped for illegal char, 2 = dropped for length
  typedef struct packed {
    logic [7:0]  n;
    logic [7:0]  fill;
    logic [63:0] chars;
    logic        use_last;
    logic [7:0]  last_b;
    logic [1:0]  exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  logic [7:0] msg [0:39];
  int         msg_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] char_at(input vec_t v, input int i);
    if (v.use_last && (i == int'(v.n) - 1)) return v.last_b;
    if (v.n <= 8) return v.chars[63 - 8*i -: 8];
    return v.fill;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg_n; i++) begin
      int w;
      in_byte  = msg[i];
      in_valid = 1'b1;
      in_last  = (i == msg_n - 1);
      w = 0;
      while (!in_ready && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_err(input bit is_long);
    chk("err_invalid_pulse", {31'd0, err_invalid_char}, {31'd0, !is_long});
    chk("err_too_long_pulse", {31'd0, err_too_long}, {31'd0, is_long});
    chk("err_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("err_no_frame", {31'd0, message_valid}, 32'd0);
    chk("err_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("err_pulse_cleared", {30'd0, err_invalid_char, err_too_long}, 32'd0);
    chk("err_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("err_busy_clear", {31'd0, busy}, 32'd0);
  endtask

  // pat bit c is message_ready on cycle c of the frame; cycles past patlen use 1.
  task automatic collect(input int patlen, input logic [15:0] pat);
    logic [7:0] e [0:41];
    int nexp, ec, ones, cyc, k;
    logic r, held;
    logic [7:0] hold;
    nexp = msg_n + 2;
    e[0] = 8'hFF;
    for (int i = 0; i < msg_n; i++) e[i+1] = msg[i];
    e[msg_n+1] = 8'h00;
    ones = 0;
    ec = 0;
    while (ones < nexp) begin
      r = (ec < patlen) ? pat[ec] : 1'b1;
      if (r) ones++;
      ec++;
    end
    chk("head_msg_len", {26'd0, msg_len}, msg_n);
    chk("frame_busy", {31'd0, busy}, 32'd1);
    cyc = 0;
    k = 0;
    held = 1'b0;
    hold = 8'h00;
    while (k < nexp && cyc < 400) begin
      r = (cyc < patlen) ? pat[cyc] : 1'b1;
      message_ready = r;
      chk("frame_valid", {31'd0, message_valid}, 32'd1);
      chk("frame_no_err", {30'd0, err_invalid_char, err_too_long}, 32'd0);
      if (held) chk("stall_hold", {24'd0, message_byte}, {24'd0, hold});
      if (r) begin
        chk("frame_byte", {24'd0, message_byte}, {24'd0, e[k]});
        k++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hold = message_byte;
      end
      tick();
      cyc++;
    end
    message_ready = 1'b1;
    chk("frame_cycles", cyc, ec);
    chk("frame_done_valid", {31'd0, message_valid}, 32'd0);
    chk("frame_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("frame_done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, message_valid}, 32'd0);
    chk({tag, "_byte"}, {24'd0, message_byte}, 32'd0);
    chk({tag, "_msg_len"}, {26'd0, msg_len}, 32'd0);
    chk({tag, "_errs"}, {30'd0, err_invalid_char, err_too_long}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'd2,  8'h00, 64'h4869_0000_0000_0000, 1'b0, 8'h00, 2'd0}; // "Hi"
    vecs[1]  = '{8'd32, 8'h41, 64'h0,                   1'b0, 8'h00, 2'd0}; // 32 x 'A'
    vecs[2]  = '{8'd33, 8'h41, 64'h0,                   1'b0, 8'h00, 2'd2}; // 33 x 'A'
    vecs[3]  = '{8'd3,  8'h00, 64'h6107_6200_0000_0000, 1'b0, 8'h00, 2'd1}; // "a",07,"b"
    vecs[4]  = '{8'd2,  8'h00, 64'h6F6B_0000_0000_0000, 1'b0, 8'h00, 2'd0}; // "ok"
`ifdef LH_FRAMER_ALNUM_ONLY_EN
    vecs[5]  = '{8'd3,  8'h00, 64'h6120_6200_0000_0000, 1'b0, 8'h00, 2'd1}; // "a b"
    vecs[9]  = '{8'd32, 8'h20, 64'h0,                   1'b1, 8'h7E, 2'd1}; // spaces + '~'
`else
    vecs[5]  = '{8'd3,  8'h00, 64'h6120_6200_0000_0000, 1'b0, 8'h00, 2'd0};
    vecs[9]  = '{8'd32, 8'h20, 64'h0,                   1'b1, 8'h7E, 2'd0};
`endif
    vecs[6]  = '{8'd1,  8'h00, 64'h5A00_0000_0000_0000, 1'b0, 8'h00, 2'd0}; // "Z"
    vecs[7]  = '{8'd1,  8'h00, 64'hFF00_0000_0000_0000, 1'b0, 8'h00, 2'd1}; // FF
    vecs[8]  = '{8'd3,  8'h00, 64'h3100_3200_0000_0000, 1'b0, 8'h00, 2'd1}; // "1",00,"2"
    vecs[10] = '{8'd34, 8'h41, 64'h0,                   1'b1, 8'h7F, 2'd1}; // long and bad
    vecs[11] = '{8'd2,  8'h00, 64'h3039_0000_0000_0000, 1'b0, 8'h00, 2'd0}; // "09"
    vecs[12] = '{8'd1,  8'h00, 64'h1F00_0000_0000_0000, 1'b0, 8'h00, 2'd1}; // 1F

    rst = 1'b1;
    in_byte = 8'h00;
    in_valid = 1'b0;
    in_last = 1'b0;
    message_ready = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < NV; v++) begin
      msg_n = int'(vecs[v].n);
      for (int i = 0; i < msg_n; i++) msg[i] = char_at(vecs[v], i);
      send_msg();
      if (vecs[v].exp == 2'd0) collect(0, 16'h0);
      else expect_err(vecs[v].exp == 2'd2);
      $display("vec %0d len %0d outcome %0d checks %0d errors %0d",
               v, msg_n, vecs[v].exp, checks, errors);
      tick();
    end

    // "AB" under a stalling consumer: ready 1,0,0,1,1,0,1
    msg_n = 2;
    msg[0] = 8'h41;
    msg[1] = 8'h42;
    send_msg();
    collect(7, 16'h0059);
    $display("stall AB checks %0d errors %0d", checks, errors);
    tick();

    // Reset during BODY of "XYZ" aborts the frame
    msg_n = 3;
    msg[0] = 8'h58;
    msg[1] = 8'h59;
    msg[2] = 8'h5A;
    send_msg();
    chk("xyz_head", {24'd0, message_byte}, 32'hFF);
    tick();
    chk("xyz_body0", {24'd0, message_byte}, 32'h58);
    rst = 1'b1;
    message_ready = 1'b0;
    tick();
    check_reset_values("midframe_reset");
    rst = 1'b0;
    message_ready = 1'b1;
    tick();
    check_reset_values("after_reset");
    msg_n = 1;
    msg[0] = 8'h51;
    send_msg();
    collect(0, 16'h0);
    $display("reset XYZ then Q checks %0d errors %0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
